byte_packer: RTL and testbench

BYTE_PACKER -- requirements
Module: byte_packer

---
 rtl/byte_packer.sv | 88 ++++++++
 tb/tb_byte_packer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Byte-to-word packer: gathers up to LANES bytes per output word,
// closing a word early on up_last, with a single output register stage.
module byte_packer #(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         up_data,
    input  logic               up_valid,
    input  logic               up_last,
    output logic               up_ready,
    output logic [8*LANES-1:0] down_data,
    output logic [LANES-1:0]   down_keep,
    output logic               down_last,
    output logic               down_valid,
    input  logic               down_ready
);

    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] CNT_MAX = CW'(LANES - 1);

    generate
        if (LANES < 2 || LANES > 8) begin : g_bad_lanes
            $error("byte_packer: LANES must be in 2..8");
        end
    endgenerate

    logic [8*(LANES-1)-1:0] acc;
    logic [CW-1:0]          cnt;
    logic [8*LANES-1:0]     acc_ext;
    logic [8*LANES-1:0]     nxt_data;
    logic [LANES-1:0]       nxt_keep;
    logic                   up_fire;
    logic                   closing;

    assign up_ready = !down_valid || down_ready;
    assign up_fire  = up_valid && up_ready;
    assign closing  = up_fire && (up_last || cnt == CNT_MAX);

    // Top lane has no accumulator slot; pad so every lane can be indexed.
    assign acc_ext = {8'h00, acc};

    always_comb begin
        nxt_data = '0;
        nxt_keep = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(cnt)) begin
                nxt_data[8*k +: 8] = acc_ext[8*k +: 8];
            end else if (k == int'(cnt)) begin
                nxt_data[8*k +: 8] = up_data;
            end
            nxt_keep[k] = (k <= int'(cnt));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            down_data  <= '0;
            down_keep  <= '0;
            down_last  <= 1'b0;
            down_valid <= 1'b0;
        end else begin
            if (closing) begin
                down_data  <= nxt_data;
                down_keep  <= nxt_keep;
                down_last  <= up_last;
                down_valid <= 1'b1;
                acc        <= '0;
                cnt        <= '0;
            end else begin
                if (down_valid && down_ready) begin
                    down_valid <= 1'b0;
                end
                if (up_fire) begin
                    for (int k = 0; k < LANES - 1; k++) begin
                        if (k == int'(cnt)) begin
                            acc[8*k +: 8] <= up_data;
                        end
                    end
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_byte_packer.sv
// Scoreboard bench for byte_packer (LANES=4): directed scenarios
// followed by a randomized ready/valid run.
module tb_byte_packer;

    localparam int LANES = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  up_data = '0;
    logic        up_valid = 1'b0;
    logic        up_last = 1'b0;
    logic        up_ready;
    logic [31:0] down_data;
    logic [3:0]  down_keep;
    logic        down_last;
    logic        down_valid;
    logic        down_ready = 1'b0;

    byte_packer #(.LANES(LANES)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_last    (up_last),
        .up_ready   (up_ready),
        .down_data  (down_data),
        .down_keep  (down_keep),
        .down_last  (down_last),
        .down_valid (down_valid),
        .down_ready (down_ready)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail = 0;
    word_t sb[$];
    logic [7:0] m_acc [4];
    int    m_cnt = 0;
    int    n_words = 0;
    int    n_lasts = 0;
    word_t lw;
    bit    rnd = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input logic l);
        word_t w;
        m_acc[m_cnt] = b;
        if (m_cnt == LANES - 1 || l) begin
            w.data = '0;
            for (int i = 0; i <= m_cnt; i++) w.data[8*i +: 8] = m_acc[i];
            w.keep = 4'((1 << (m_cnt + 1)) - 1);
            w.last = l;
            sb.push_back(w);
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_acc[i] = '0;
        end else begin
            m_cnt++;
        end
    endtask

    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            sb.delete();
            m_cnt = 0;
            for (int i = 0; i < 4; i++) m_acc[i] = '0;
        end else begin
            check("up_ready", up_ready, !down_valid || down_ready);
            if (down_valid && down_ready) begin
                n_words++;
                if (down_last) n_lasts++;
                lw.data = down_data;
                lw.keep = down_keep;
                lw.last = down_last;
                if (sb.size() == 0) begin
                    check("unexpected_word", down_data, 64'hdead);
                end else begin
                    e = sb.pop_front();
                    check("word_data", down_data, e.data);
                    check("word_keep", down_keep, e.keep);
                    check("word_last", down_last, e.last);
                end
            end
            if (up_valid && up_ready) model_accept(up_data, up_last);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd) down_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        up_data = d;
        up_last = l;
        forever begin
            up_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (up_valid && up_ready) begin
                tick();
                up_valid = 1'b0;
                return;
            end
            tick();
            n++;
            if (n > 200) begin
                check("accept_timeout", 0, 1);
                up_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || down_valid) && n < 300) begin
            tick();
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        int w0;
        int pkts;
        int len;
        int sent;

        repeat (2) tick();
        check("rst_valid", down_valid, 0);
        check("rst_data", down_data, 0);
        check("rst_keep", down_keep, 0);
        check("rst_last", down_last, 0);
        rst = 1'b0;
        check("rdy_after_rst", up_ready, 1);

        // Full words, continuous stream
        down_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_byte(8'(i), i == 8);
            if (i == 3 || i == 7) check("no_early_word", down_valid, 0);
            if (i == 4 || i == 8) check("lat_one", down_valid, 1);
            if (i == 4) check("w0_data", down_data, 32'h04030201);
            if (i == 8) check("w1_data", down_data, 32'h08070605);
        end
        tick();

        // Partial tail and single-byte packet
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 1);
        tick();
        check("tail_data", lw.data, 32'h00CCBBAA);
        check("tail_keep", lw.keep, 4'h7);
        check("tail_last", lw.last, 1);
        send_byte(8'h5A, 1);
        tick();
        check("one_data", lw.data, 32'h0000005A);
        check("one_keep", lw.keep, 4'h1);
        check("one_last", lw.last, 1);

        // Backpressure on a held word
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 0);
        down_ready = 1'b0;
        up_valid = 1'b1;
        up_data = 8'h05;
        up_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", up_ready, 0);
            check("bp_valid", down_valid, 1);
            check("bp_data", down_data, 32'h04030201);
            check("bp_keep", down_keep, 4'hF);
            tick();
        end
        down_ready = 1'b1;
        w0 = n_words;
        @(negedge clk);
        check("bp_release_rdy", up_ready, 1);
        tick();
        up_valid = 1'b0;
        check("bp_release_word", n_words - w0, 1);
        send_byte(8'h06, 0);
        send_byte(8'h07, 0);
        send_byte(8'h08, 1);
        drain();

        // Reset mid-packet discards held bytes
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", down_valid, 0);
        w0 = n_words;
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 1);
        drain();
        check("mid_rst_words", n_words - w0, 1);
        check("mid_rst_data", lw.data, 32'h66554433);
        check("mid_rst_keep", lw.keep, 4'hF);

        // Randomized traffic
        rnd = 1'b1;
        w0 = n_lasts;
        pkts = 0;
        sent = 0;
        while (sent < 10000) begin
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) begin
                send_byte(8'($urandom), i == len - 1);
            end
            sent += len;
            pkts++;
        end
        up_valid = 1'b0;
        drain();
        check("rand_last_count", n_lasts - w0, pkts);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
